multi_cycle_ctrl: RTL and testbench

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multicycle_pkg.sv | 45 ++++
 rtl/multi_cycle_ctrl.sv | 139 +++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encoding,
// opcodes, and the mux/ALU class codes driven onto the datapath.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: one state register, a next-state decoder and
// a Moore-style output decoder (plus mem_ready/zero gating where required).
module multi_cycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int unsigned MEM_WAIT_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [1:0] ALUOp,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       PCEn,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t state;
  state_t state_next;
  logic   mem_rdy;

  assign mem_rdy = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:   state_next = mem_rdy ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = RTYPEEX;
          OP_BEQ:       state_next = BEQEX;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JEX;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR:  state_next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_next = mem_rdy ? MEMWB : MEMRD;
      MEMWB:   state_next = FETCH;
      MEMWR:   state_next = mem_rdy ? FETCH : MEMWR;
      RTYPEEX: state_next = RTYPEWB;
      RTYPEWB: state_next = FETCH;
      BEQEX:   state_next = FETCH;
      ADDIEX:  state_next = ADDIWB;
      ADDIWB:  state_next = FETCH;
      JEX:     state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Outputs are gated by rst_n directly so they drop in the same cycle the
  // reset is asserted, not only after the state register has been cleared.
  always_comb begin
    IorD       = 1'b0;
    ALUSrcA    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcB    = SRCB_REG;
    PCSrc      = PCSRC_ALU;
    ALUOp      = ALUOP_ADD;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    PCEn       = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH: begin
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_rdy;
          PCEn    = mem_rdy;
        end
        DECODE: begin
          ALUSrcB    = SRCB_IMM_SH;
          illegal_op = !op_supported(op);
        end
        MEMADR, ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        MEMRD: IorD = 1'b1;
        MEMWB: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        MEMWR: begin
          IorD       = 1'b1;
          MemWrite   = 1'b1;
          instr_done = mem_rdy;
        end
        RTYPEEX: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
        end
        RTYPEWB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        BEQEX: begin
          ALUSrcA    = 1'b1;
          ALUOp      = ALUOP_SUB;
          PCSrc      = PCSRC_ALUOUT;
          PCEn       = zero;
          instr_done = 1'b1;
        end
        ADDIWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        JEX: begin
          PCSrc      = PCSRC_JUMP;
          PCEn       = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl; outputs are packed into a 16-bit vector
// {IorD,ALUSrcA,RegDst,MemtoReg,ALUSrcB,PCSrc,ALUOp,IRWrite,MemWrite,RegWrite,PCEn,instr_done,illegal_op}.
module tb_multi_cycle_ctrl;
  import multicycle_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;

  logic       IorD, ALUSrcA, RegDst, MemtoReg, IRWrite, MemWrite, RegWrite, PCEn, instr_done, illegal_op;
  logic [1:0] ALUSrcB, PCSrc, ALUOp;
  logic       n_IorD, n_ALUSrcA, n_RegDst, n_MemtoReg, n_IRWrite, n_MemWrite, n_RegWrite, n_PCEn, n_instr_done, n_illegal_op;
  logic [1:0] n_ALUSrcB, n_PCSrc, n_ALUOp;

  logic [15:0] outs, outs_nw;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned done_cnt, mw_cnt;

  localparam logic [15:0] E_ZERO     = 16'b0_0_0_0_00_00_00_0_0_0_0_0_0;
  localparam logic [15:0] E_FETCH_R  = 16'b0_0_0_0_01_00_00_1_0_0_1_0_0;
  localparam logic [15:0] E_FETCH_NR = 16'b0_0_0_0_01_00_00_0_0_0_0_0_0;
  localparam logic [15:0] E_DECODE   = 16'b0_0_0_0_11_00_00_0_0_0_0_0_0;
  localparam logic [15:0] E_DEC_ILL  = 16'b0_0_0_0_11_00_00_0_0_0_0_0_1;
  localparam logic [15:0] E_MEMADR   = 16'b0_1_0_0_10_00_00_0_0_0_0_0_0;
  localparam logic [15:0] E_MEMRD    = 16'b1_0_0_0_00_00_00_0_0_0_0_0_0;
  localparam logic [15:0] E_MEMWB    = 16'b0_0_0_1_00_00_00_0_0_1_0_1_0;
  localparam logic [15:0] E_MEMWR_NR = 16'b1_0_0_0_00_00_00_0_1_0_0_0_0;
  localparam logic [15:0] E_MEMWR_R  = 16'b1_0_0_0_00_00_00_0_1_0_0_1_0;
  localparam logic [15:0] E_RTYPEEX  = 16'b0_1_0_0_00_00_10_0_0_0_0_0_0;
  localparam logic [15:0] E_RTYPEWB  = 16'b0_0_1_0_00_00_00_0_0_1_0_1_0;
  localparam logic [15:0] E_BEQ_Z    = 16'b0_1_0_0_00_01_01_0_0_0_1_1_0;
  localparam logic [15:0] E_BEQ_NZ   = 16'b0_1_0_0_00_01_01_0_0_0_0_1_0;
  localparam logic [15:0] E_ADDIWB   = 16'b0_0_0_0_00_00_00_0_0_1_0_1_0;
  localparam logic [15:0] E_JEX      = 16'b0_0_0_0_00_10_00_0_0_0_1_1_0;

  always #5 clk = ~clk;

  multi_cycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .IorD(IorD), .ALUSrcA(ALUSrcA), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .PCEn(PCEn),
    .instr_done(instr_done), .illegal_op(illegal_op)
  );

  multi_cycle_ctrl #(.MEM_WAIT_EN(0)) dut_nw (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(1'b0),
    .IorD(n_IorD), .ALUSrcA(n_ALUSrcA), .RegDst(n_RegDst), .MemtoReg(n_MemtoReg),
    .ALUSrcB(n_ALUSrcB), .PCSrc(n_PCSrc), .ALUOp(n_ALUOp),
    .IRWrite(n_IRWrite), .MemWrite(n_MemWrite), .RegWrite(n_RegWrite), .PCEn(n_PCEn),
    .instr_done(n_instr_done), .illegal_op(n_illegal_op)
  );

  assign outs    = {IorD, ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSrc, ALUOp,
                    IRWrite, MemWrite, RegWrite, PCEn, instr_done, illegal_op};
  assign outs_nw = {n_IorD, n_ALUSrcA, n_RegDst, n_MemtoReg, n_ALUSrcB, n_PCSrc, n_ALUOp,
                    n_IRWrite, n_MemWrite, n_RegWrite, n_PCEn, n_instr_done, n_illegal_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs already set; sample at the falling edge, then
  // advance past the next rising edge.
  task automatic cyc(input string tag, input logic [15:0] exp, input state_t st, input bit nw);
    @(negedge clk);
    if (nw) begin
      check({tag, "_out"}, 32'(outs_nw), 32'(exp));
      check({tag, "_st"}, 32'(dut_nw.state), 32'(st));
      done_cnt += 32'(n_instr_done);
    end else begin
      check({tag, "_out"}, 32'(outs), 32'(exp));
      check({tag, "_st"}, 32'(dut.state), 32'(st));
      done_cnt += 32'(instr_done);
      mw_cnt   += 32'(MemWrite);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; op = OP_LW; zero = 1'b0;
    #2;
    check("rst_out", 32'(outs), 32'(E_ZERO));
    check("rst_st", 32'(dut.state), 32'(FETCH));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // lw, memory always ready: 5 cycles, one done pulse
    done_cnt = 0;
    cyc("lw_f", E_FETCH_R, FETCH, 0);
    cyc("lw_d", E_DECODE, DECODE, 0);
    cyc("lw_a", E_MEMADR, MEMADR, 0);
    cyc("lw_r", E_MEMRD, MEMRD, 0);
    cyc("lw_wb", E_MEMWB, MEMWB, 0);
    check("lw_done_cnt", done_cnt, 1);

    // beq taken
    op = OP_BEQ; zero = 1'b1;
    cyc("beqz_f", E_FETCH_R, FETCH, 0);
    cyc("beqz_d", E_DECODE, DECODE, 0);
    cyc("beqz_x", E_BEQ_Z, BEQEX, 0);
    // beq not taken
    zero = 1'b0;
    cyc("beqn_f", E_FETCH_R, FETCH, 0);
    cyc("beqn_d", E_DECODE, DECODE, 0);
    cyc("beqn_x", E_BEQ_NZ, BEQEX, 0);

    // sw with three wait cycles in MEMWR
    op = OP_SW; done_cnt = 0; mw_cnt = 0;
    cyc("sw_f", E_FETCH_R, FETCH, 0);
    cyc("sw_d", E_DECODE, DECODE, 0);
    cyc("sw_a", E_MEMADR, MEMADR, 0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("sw_wait", E_MEMWR_NR, MEMWR, 0);
    mem_ready = 1'b1;
    cyc("sw_w", E_MEMWR_R, MEMWR, 0);
    check("sw_mw_cnt", mw_cnt, 4);
    check("sw_done_cnt", done_cnt, 1);

    // illegal opcode
    op = 6'b111111;
    cyc("ill_f", E_FETCH_R, FETCH, 0);
    cyc("ill_d", E_DEC_ILL, DECODE, 0);

    // fetch stall, then j
    op = OP_J; mem_ready = 1'b0;
    cyc("stall_f0", E_FETCH_NR, FETCH, 0);
    cyc("stall_f1", E_FETCH_NR, FETCH, 0);
    mem_ready = 1'b1;
    cyc("j_f", E_FETCH_R, FETCH, 0);
    cyc("j_d", E_DECODE, DECODE, 0);
    cyc("j_x", E_JEX, JEX, 0);

    // addi
    op = OP_ADDI;
    cyc("addi_f", E_FETCH_R, FETCH, 0);
    cyc("addi_d", E_DECODE, DECODE, 0);
    cyc("addi_x", E_MEMADR, ADDIEX, 0);
    cyc("addi_wb", E_ADDIWB, ADDIWB, 0);

    // reset dropped between edges while in RTYPEEX
    op = OP_RTYPE;
    cyc("rr_f", E_FETCH_R, FETCH, 0);
    cyc("rr_d", E_DECODE, DECODE, 0);
    @(negedge clk);
    check("rr_x_out", 32'(outs), 32'(E_RTYPEEX));
    #1 rst_n = 1'b0;
    #1;
    check("rr_abort_out", 32'(outs), 32'(E_ZERO));
    check("rr_abort_st", 32'(dut.state), 32'(FETCH));
    @(posedge clk); #1;
    mem_ready = 1'b0;
    rst_n = 1'b1;
    cyc("rr_rel_nr", E_FETCH_NR, FETCH, 0);
    mem_ready = 1'b1;
    cyc("rr_rel_r", E_FETCH_R, FETCH, 0);
    cyc("rr_d2", E_DECODE, DECODE, 0);
    cyc("rr_x2", E_RTYPEEX, RTYPEEX, 0);
    cyc("rr_wb", E_RTYPEWB, RTYPEWB, 0);

    // MEM_WAIT_EN=0 instance with mem_ready tied low: R-type in 4 cycles
    rst_n = 1'b0; mem_ready = 1'b0; op = OP_RTYPE;
    @(posedge clk); #1;
    rst_n = 1'b1; done_cnt = 0;
    cyc("nw_f", E_FETCH_R, FETCH, 1);
    cyc("nw_d", E_DECODE, DECODE, 1);
    cyc("nw_x", E_RTYPEEX, RTYPEEX, 1);
    cyc("nw_wb", E_RTYPEWB, RTYPEWB, 1);
    check("nw_done_cnt", done_cnt, 1);
    cyc("nw_f2", E_FETCH_R, FETCH, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
